// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller:
// scan FSM state type, blank segment pattern and active-low polarity levels.
package seg_pkg;

    // Segment pattern with every segment dark (active-low {g,f,e,d,c,b,a}).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low anode levels.
    localparam logic AN_ON  = 1'b0;
    localparam logic AN_OFF = 1'b1;

    // Two phases per digit slot: dead-time with all anodes off, then lit.
    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/vsevenseg.sv
// Combinational hex-to-seven-segment decoder.
// Output is active-low, bit order {g,f,e,d,c,b,a}.
module vsevenseg (
    input  logic [3:0] x,
    output logic [6:0] seg_L
);

    // Map a hex nibble to its active-low segment pattern.
    always_comb begin
        seg_L = 7'h7F;
        case (x)
            4'h0: seg_L = 7'h40;
            4'h1: seg_L = 7'h79;
            4'h2: seg_L = 7'h24;
            4'h3: seg_L = 7'h30;
            4'h4: seg_L = 7'h19;
            4'h5: seg_L = 7'h12;
            4'h6: seg_L = 7'h02;
            4'h7: seg_L = 7'h78;
            4'h8: seg_L = 7'h00;
            4'h9: seg_L = 7'h10;
            4'hA: seg_L = 7'h08;
            4'hB: seg_L = 7'h03;
            4'hC: seg_L = 7'h46;
            4'hD: seg_L = 7'h21;
            4'hE: seg_L = 7'h06;
            4'hF: seg_L = 7'h0E;
            default: seg_L = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode
// seven-segment display. One shared decoder, double-buffered value that
// only changes at frame boundaries, and a blanking dead-time before each
// digit to avoid ghosting.
//
// Handshake: load is a single-cycle strobe with no back-pressure; the
// captured value is held in a pending buffer (pending=1) until the last ON
// cycle of digit N-1, where it moves to the displayed shadow register. A
// load landing on that very cycle goes straight to the shadow register.
//
// Optional build macro SEG_SCAN_LZ_SUPPRESS_EN: when defined, leading zero
// digits (all nibbles from i upward are zero, i>0) are kept dark.
//
// All display outputs are registered and computed from the next state, so
// they line up with the FSM state of the same cycle.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int ON_CYC    = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     blank_mask,
    output logic [N_DIGITS-1:0]     an_L,
    output logic [6:0]              seg_L,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int VW      = 4 * N_DIGITS;
    localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IW      = $clog2(N_DIGITS);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    // Scan state
    scan_state_t       state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wrap;

    // Value buffering
    logic [VW-1:0]     shadow_q, shadow_d;
    logic [VW-1:0]     buf_q, buf_d;
    logic              pending_q, pending_d;

    // Registered outputs
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                tick_q, tick_d;

    // Display path helpers
    logic [3:0]          nib;
    logic [6:0]          dec_seg;
    logic                mask_dark;
    logic                dark;

    // Scan FSM: count out BLANK then ON for each digit, advancing the digit
    // index at the end of every ON phase.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CW'(1);
        wrap    = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = BLANK;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Double buffer: loads park in the pending buffer and are promoted to
    // the shadow register only on the wrap cycle; a load on the wrap cycle
    // itself bypasses the buffer.
    always_comb begin
        shadow_d  = shadow_q;
        buf_d     = buf_q;
        pending_d = pending_q;
        if (wrap) begin
            if (load) begin
                shadow_d  = value;
                pending_d = 1'b0;
            end else if (pending_q) begin
                shadow_d  = buf_q;
                pending_d = 1'b0;
            end
        end else if (load) begin
            buf_d     = value;
            pending_d = 1'b1;
        end
    end

    // Select the nibble of the digit about to be shown and the
    // externally requested blanking for that digit.
    always_comb begin
        nib       = 4'h0;
        mask_dark = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                nib       = shadow_d[4*i +: 4];
                mask_dark = blank_mask[i];
            end
        end
    end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    logic lz_dark;
    logic upper_zero;

    // A digit above 0 is a leading zero when it and every higher nibble is 0.
    always_comb begin
        lz_dark    = 1'b0;
        upper_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (shadow_d[4*i +: 4] == 4'h0);
            if (idx_d == IW'(i)) begin
                lz_dark = upper_zero;
            end
        end
    end

    assign dark = mask_dark | lz_dark;
`else
    assign dark = mask_dark;
`endif

    // Single shared decoder fed by the muxed nibble.
    vsevenseg u_dec (
        .x     (nib),
        .seg_L (dec_seg)
    );

    // Output drive for the upcoming cycle: one anode low only in a lit,
    // non-dark ON phase; otherwise everything off.
    always_comb begin
        an_d   = {N_DIGITS{AN_OFF}};
        seg_d  = SEG_BLANK;
        tick_d = wrap;
        if (state_d == ON && !dark) begin
            seg_d = dec_seg;
            for (int i = 0; i < N_DIGITS; i++) begin
                if (idx_d == IW'(i)) begin
                    an_d[i] = AN_ON;
                end
            end
        end
    end

    // State, buffer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            buf_q     <= '0;
            pending_q <= 1'b0;
            an_q      <= {N_DIGITS{AN_OFF}};
            seg_q     <= SEG_BLANK;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            buf_q     <= buf_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            tick_q    <= tick_d;
        end
    end

    assign an_L       = an_q;
    assign seg_L      = seg_q;
    assign frame_tick = tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with N_DIGITS=4, ON_CYC=4, BLANK_CYC=2.
// Reference model tracks the position inside a 24-cycle frame with plain
// arithmetic and derives the expected display from it.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int ONC   = 4;
    localparam int BLC   = 2;
    localparam int SLOT  = ONC + BLC;
    localparam int FRAME = N * SLOT;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT signals
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank_mask;
    logic [3:0]  an_L;
    logic [6:0]  seg_L;
    logic        frame_tick;
    logic        pending;

    seg_scan_ctrl #(
        .N_DIGITS  (N),
        .ON_CYC    (ONC),
        .BLANK_CYC (BLC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .blank_mask (blank_mask),
        .an_L       (an_L),
        .seg_L      (seg_L),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    // Scoreboard counters
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model
    logic [6:0]  hex_tab [16];
    int          pos;
    logic [15:0] m_shadow;
    logic [15:0] m_buf;
    logic        m_pend;
    logic        m_tick;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;

    function automatic void model_outputs(input logic [3:0] mask);
        int          digit;
        bit          lit;
        bit          dark;
        logic [15:0] sh;
        digit = pos / SLOT;
        lit   = (pos % SLOT) >= BLC;
        dark  = mask[digit];
        sh    = m_shadow >> (4 * digit);
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        if (digit > 0 && sh == 16'h0) dark = 1'b1;
`endif
        m_an  = 4'hF;
        m_seg = 7'h7F;
        if (lit && !dark) begin
            m_an[digit] = 1'b0;
            m_seg       = hex_tab[sh[3:0]];
        end
    endfunction

    function automatic void model_edge();
        bit wrap;
        if (!rst_n) begin
            pos      = 0;
            m_shadow = '0;
            m_buf    = '0;
            m_pend   = 1'b0;
            m_tick   = 1'b0;
            m_an     = 4'hF;
            m_seg    = 7'h7F;
        end else begin
            wrap = (pos == FRAME - 1);
            if (wrap) begin
                if (load) begin
                    m_shadow = value;
                    m_pend   = 1'b0;
                end else if (m_pend) begin
                    m_shadow = m_buf;
                    m_pend   = 1'b0;
                end
            end else if (load) begin
                m_buf  = value;
                m_pend = 1'b1;
            end
            pos    = (pos + 1) % FRAME;
            m_tick = (pos == 0);
            model_outputs(blank_mask);
        end
    endfunction

    // Driver: one clock edge, update model, compare all outputs, drop load.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("an_L", 32'(an_L), 32'(m_an));
        check_eq("seg_L", 32'(seg_L), 32'(m_seg));
        check_eq("frame_tick", 32'(frame_tick), 32'(m_tick));
        check_eq("pending", 32'(pending), 32'(m_pend));
        load = 1'b0;
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < FRAME; i++) begin
            if (pos == p) break;
            step();
        end
    endtask

    int first_tick;
    int ones_seen;

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        pos = 0; m_shadow = '0; m_buf = '0; m_pend = 1'b0; m_tick = 1'b0;
        m_an = 4'hF; m_seg = 7'h7F;
        rst_n = 1'b0; load = 1'b0; value = '0; blank_mask = '0;

        // Reset and first frame timing
        repeat (3) step();
        rst_n = 1'b1;
        check_eq("rst_an", 32'(an_L), 32'h0F);
        check_eq("rst_seg", 32'(seg_L), 32'h7F);
        check_eq("rst_tick", 32'(frame_tick), 32'h0);
        check_eq("rst_pend", 32'(pending), 32'h0);
        first_tick = -1;
        for (int k = 1; k <= FRAME + 1; k++) begin
            step();
            if (k == 1) begin
                check_eq("blank1_an", 32'(an_L), 32'h0F);
                check_eq("blank1_seg", 32'(seg_L), 32'h7F);
            end
            if (k >= 2 && k <= 5) begin
                check_eq("d0_an", 32'(an_L), 32'h0E);
                check_eq("d0_seg", 32'(seg_L), 32'h40);
            end
            if (frame_tick && first_tick < 0) first_tick = k;
        end
        check_eq("first_tick_cycle", 32'(first_tick), 32'd24);

        // Mid-frame load
        goto_pos(10);
        value = 16'h1A3F; load = 1'b1;
        step();
        check_eq("mid_pending", 32'(pending), 32'h1);
        goto_pos(FRAME - 1);
        check_eq("pend_at_wrap", 32'(pending), 32'h1);
        goto_pos(2);
        check_eq("mid_d0_an", 32'(an_L), 32'h0E);
        check_eq("mid_d0_seg", 32'(seg_L), 32'h0E);
        goto_pos(8);
        check_eq("mid_d1_an", 32'(an_L), 32'h0D);
        check_eq("mid_d1_seg", 32'(seg_L), 32'h30);
        goto_pos(14);
        check_eq("mid_d2_an", 32'(an_L), 32'h0B);
        check_eq("mid_d2_seg", 32'(seg_L), 32'h08);
        goto_pos(20);
        check_eq("mid_d3_an", 32'(an_L), 32'h07);
        check_eq("mid_d3_seg", 32'(seg_L), 32'h79);

        // Load exactly on the wrap cycle
        goto_pos(FRAME - 1);
        value = 16'h0005; load = 1'b1;
        step();
        check_eq("wrap_load_pend", 32'(pending), 32'h0);
        check_eq("wrap_tick", 32'(frame_tick), 32'h1);
        goto_pos(2);
        check_eq("wrap_d0_seg", 32'(seg_L), 32'h12);

        // Double load within one frame: last write wins
        goto_pos(3);
        value = 16'h1111; load = 1'b1;
        step();
        goto_pos(8);
        value = 16'h2222; load = 1'b1;
        step();
        goto_pos(0);
        ones_seen = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (seg_L == 7'h79) ones_seen++;
        end
        check_eq("no_1111_shown", 32'(ones_seen), 32'd0);
        goto_pos(2);
        check_eq("dbl_d0_seg", 32'(seg_L), 32'h24);

        // Blank mask on digit 2
        blank_mask = 4'b0100;
        goto_pos(14);
        check_eq("mask_d2_an", 32'(an_L), 32'h0F);
        check_eq("mask_d2_seg", 32'(seg_L), 32'h7F);
        goto_pos(20);
        check_eq("mask_d3_an", 32'(an_L), 32'h07);
        goto_pos(0);
        for (int k = 1; k <= FRAME; k++) step();
        check_eq("mask_frame_len", 32'(frame_tick), 32'h1);
        blank_mask = 4'b0000;

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        // Leading-zero suppression
        value = 16'h0070; load = 1'b1;
        step();
        goto_pos(FRAME - 1);
        goto_pos(2);
        check_eq("lz_d0_seg", 32'(seg_L), 32'h40);
        goto_pos(8);
        check_eq("lz_d1_seg", 32'(seg_L), 32'h78);
        goto_pos(14);
        check_eq("lz_d2_an", 32'(an_L), 32'h0F);
        goto_pos(20);
        check_eq("lz_d3_an", 32'(an_L), 32'h0F);
        value = 16'h0000; load = 1'b1;
        step();
        goto_pos(FRAME - 1);
        goto_pos(2);
        check_eq("lz0_d0_seg", 32'(seg_L), 32'h40);
        goto_pos(8);
        check_eq("lz0_d1_an", 32'(an_L), 32'h0F);
`endif

        // Randomized traffic with occasional mask changes and resets
        for (int k = 0; k < 2500; k++) begin
            load  = ($urandom_range(0, 11) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 47) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 5) == 0) value[15:8] = 8'h00;
            rst_n = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
